riscv_mem_arbiter: RTL and testbench

- Parametrised N-port arbiter in front of the single-ported data memory, so several initiators (core load/store unit, debug/DMA port, future second hart) can share it.
- Round-robin grant, one outstanding transaction, fixed-latency read return, alignment check.
- Instantiated in the top-level wrapper between the initiators and the data memory; the memory interface is unchanged (rd_en/wr_en/addr/wdata/rdata).

---
 rtl/riscv_mem_pkg.sv | 11 +
 rtl/riscv_mem_arbiter_rr_arbiter.sv | 30 +++
 rtl/riscv_mem_arbiter.sv | 75 +++++++
 tb/tb_riscv_mem_arbiter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state type and sizing helpers for the data-memory arbiter
package riscv_mem_pkg;
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int OFF_W = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int off_w(input int dw);
    return (dw > 8) ? $clog2(dw / 8) : 0;
  endfunction
endpackage

// File: rtl/riscv_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  localparam logic [IW:0] NL = (IW + 1)'(N);
  logic [2*N-1:0] rot;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  assign rot = {req, req} >> ptr;
  always_comb begin
    off = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = IW'(k);
        any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    idx = (sum >= NL) ? IW'(sum - NL) : IW'(sum);
    gnt = any ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: round-robin N-port front end for the single-ported data memory
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [NUM_PORTS-1:0]          err,
  output logic                          mem_rd_en,
  output logic                          mem_wr_en,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);
  localparam int IW = idx_w(NUM_PORTS);
  localparam logic [ADDR_W-1:0] MASK = ADDR_W'(DATA_W / 8 - 1);
  localparam logic [IW:0] NL = (IW + 1)'(NUM_PORTS);
  state_t state, state_n;
  logic [2:0]            cnt;
  logic [IW-1:0]         ptr, owner, idx, ptr_n;
  logic [NUM_PORTS-1:0]  arb_req, arb_gnt;
  logic                  any, mis, done;
  logic [ADDR_W-1:0]     win_addr;
  rr_arbiter #(.N(NUM_PORTS), .IW(IW)) u_rr (
    .req(arb_req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(idx),
    .any(any)
  );
  always_comb begin
    arb_req   = (state == IDLE && !reset) ? req : '0;
    win_addr  = addr[idx*ADDR_W +: ADDR_W];
    mis       = |(win_addr & MASK);
    gnt       = arb_gnt;
    err       = mis ? arb_gnt : '0;
    mem_wr_en = any & we[idx] & ~mis;
    mem_rd_en = any & ~we[idx] & ~mis;
    mem_addr  = (mem_wr_en | mem_rd_en) ? win_addr : '0;
    mem_wdata = mem_wr_en ? wdata[idx*DATA_W +: DATA_W] : '0;
    busy      = state == WAIT;
    done      = busy && cnt == 3'd1;
    ptr_n     = ({1'b0, idx} + 1'b1 == NL) ? '0 : idx + 1'b1;
    state_n   = (state == IDLE) ? (mem_rd_en ? WAIT : IDLE) : (done ? IDLE : WAIT);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      ptr    <= '0;
      owner  <= '0;
      rdata  <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_n;
      ptr    <= any ? ptr_n : ptr;
      owner  <= mem_rd_en ? idx : owner;
      cnt    <= mem_rd_en ? 3'(MEM_LATENCY) : (busy ? cnt - 3'd1 : cnt);
      rvalid <= done ? (NUM_PORTS'(1) << owner) : '0;
      rdata  <= done ? mem_rdata : rdata;
    end
  end
endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks of grant order, read latency, alignment and reset
module tb_riscv_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int pass = 0;
  int total = 0;
  logic [1:0]   req2 = '0, we2 = '0;
  logic [63:0]  addr2 = '0, wdata2 = '0;
  logic [3:0]   req4 = '0, we4 = '0;
  logic [127:0] addr4 = '0, wdata4 = '0;
  logic [1:0]  gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
  logic [3:0]  gnt_c, rvalid_c, err_c;
  logic [31:0] rdata_a, maddr_a, mwd_a, mrdata_a, la_a = '0;
  logic [31:0] rdata_b, maddr_b, mwd_b, mrdata_b, la_b = '0;
  logic [31:0] rdata_c, maddr_c, mwd_c, mrdata_c, la_c = '0;
  logic mrd_a, mwr_a, busy_a, mrd_b, mwr_b, busy_b, mrd_c, mwr_c, busy_c;
  always_ff @(posedge clk) begin
    if (mrd_a) la_a <= maddr_a;
    if (mrd_b) la_b <= maddr_b;
    if (mrd_c) la_c <= maddr_c;
  end
  assign mrdata_a = la_a ^ 32'hDEADBEFF;
  assign mrdata_b = la_b ^ 32'hDEADBEFF;
  assign mrdata_c = la_c ^ 32'hDEADBEFF;
  riscv_mem_arbiter #(.NUM_PORTS(2), .MEM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .gnt(gnt_a), .rvalid(rvalid_a), .rdata(rdata_a), .err(err_a),
    .mem_rd_en(mrd_a), .mem_wr_en(mwr_a), .mem_addr(maddr_a), .mem_wdata(mwd_a),
    .mem_rdata(mrdata_a), .busy(busy_a)
  );
  riscv_mem_arbiter #(.NUM_PORTS(2), .MEM_LATENCY(3)) u_b (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .gnt(gnt_b), .rvalid(rvalid_b), .rdata(rdata_b), .err(err_b),
    .mem_rd_en(mrd_b), .mem_wr_en(mwr_b), .mem_addr(maddr_b), .mem_wdata(mwd_b),
    .mem_rdata(mrdata_b), .busy(busy_b)
  );
  riscv_mem_arbiter #(.NUM_PORTS(4), .MEM_LATENCY(1)) u_c (
    .clk(clk), .reset(reset), .req(req4), .we(we4), .addr(addr4), .wdata(wdata4),
    .gnt(gnt_c), .rvalid(rvalid_c), .rdata(rdata_c), .err(err_c),
    .mem_rd_en(mrd_c), .mem_wr_en(mwr_c), .mem_addr(maddr_c), .mem_wdata(mwd_c),
    .mem_rdata(mrdata_c), .busy(busy_c)
  );
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req2 = '0; we2 = '0; req4 = '0; we4 = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    addr2[31:0] = 32'h10;
    req2 = 2'b01;
    #1;
    total++; if (gnt_a !== 2'b01) $display("FAIL rst_gnt: got %b want 01", gnt_a); else pass++;
    total++; if (mrd_a !== 1'b1 || maddr_a !== 32'h10) $display("FAIL rst_rd: got rd=%b addr=%h want 1/10", mrd_a, maddr_a); else pass++;
    @(negedge clk);
    req2 = '0;
    reset = 1'b1;
    #1;
    total++; if (mrd_a !== 1'b0 || gnt_a !== 2'b00) $display("FAIL rst_quiet: got rd=%b gnt=%b want 0/00", mrd_a, gnt_a); else pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (rvalid_a !== 2'b00) $display("FAIL rst_norvalid: got %b want 00", rvalid_a); else pass++;
    total++; if (busy_a !== 1'b0 || rdata_a !== 32'h0) $display("FAIL rst_state: got busy=%b rdata=%h want 0/0", busy_a, rdata_a); else pass++;
    @(negedge clk);
    req2 = 2'b11; we2 = 2'b11;
    addr2 = {32'h200, 32'h100};
    #1;
    total++; if (rvalid_a !== 2'b00) $display("FAIL rst_norvalid2: got %b want 00", rvalid_a); else pass++;
    total++; if (gnt_a !== 2'b01) $display("FAIL rst_ptr: got %b want 01", gnt_a); else pass++;
  endtask
  task automatic test_single_read();
    do_reset();
    addr2[31:0] = 32'h10;
    req2 = 2'b01;
    #1;
    total++; if (gnt_a !== 2'b01 || mrd_a !== 1'b1) $display("FAIL rd_issue_a: got gnt=%b rd=%b want 01/1", gnt_a, mrd_a); else pass++;
    total++; if (gnt_b !== 2'b01 || mrd_b !== 1'b1) $display("FAIL rd_issue_b: got gnt=%b rd=%b want 01/1", gnt_b, mrd_b); else pass++;
    @(negedge clk);
    req2 = '0;
    #1;
    total++; if (busy_a !== 1'b1 || rvalid_a !== 2'b00) $display("FAIL rd_wait: got busy=%b rvalid=%b want 1/00", busy_a, rvalid_a); else pass++;
    @(negedge clk);
    #1;
    total++; if (rvalid_a !== 2'b01 || rdata_a !== 32'hDEADBEEF) $display("FAIL rd_lat1: got rvalid=%b rdata=%h want 01/deadbeef", rvalid_a, rdata_a); else pass++;
    total++; if (busy_a !== 1'b0 || rvalid_b !== 2'b00) $display("FAIL rd_lat3_early: got busy_a=%b rvalid_b=%b want 0/00", busy_a, rvalid_b); else pass++;
    @(negedge clk);
    #1;
    total++; if (rvalid_a !== 2'b00 || rdata_a !== 32'hDEADBEEF) $display("FAIL rd_hold: got rvalid=%b rdata=%h want 00/deadbeef", rvalid_a, rdata_a); else pass++;
    total++; if (rvalid_b !== 2'b00 || busy_b !== 1'b1) $display("FAIL rd_lat3_wait: got rvalid=%b busy=%b want 00/1", rvalid_b, busy_b); else pass++;
    @(negedge clk);
    #1;
    total++; if (rvalid_b !== 2'b01 || rdata_b !== 32'hDEADBEEF) $display("FAIL rd_lat3: got rvalid=%b rdata=%h want 01/deadbeef", rvalid_b, rdata_b); else pass++;
  endtask
  task automatic test_contention();
    logic [1:0]  eg;
    logic [31:0] ea, ed;
    do_reset();
    req2 = 2'b11; we2 = 2'b11;
    addr2 = {32'h200, 32'h100};
    wdata2 = {32'hBBBB_0001, 32'hAAAA_0000};
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      ea = (i % 2 == 1) ? 32'h200 : 32'h100;
      ed = (i % 2 == 1) ? 32'hBBBB_0001 : 32'hAAAA_0000;
      if (i > 0) @(negedge clk);
      #1;
      total++; if (gnt_a !== eg || mwr_a !== 1'b1) $display("FAIL cont_gnt%0d: got gnt=%b wr=%b want %b/1", i, gnt_a, mwr_a, eg); else pass++;
      total++; if (maddr_a !== ea || mwd_a !== ed) $display("FAIL cont_bus%0d: got %h/%h want %h/%h", i, maddr_a, mwd_a, ea, ed); else pass++;
    end
  endtask
  task automatic test_read_blocks();
    do_reset();
    req2 = 2'b01; we2 = 2'b01;
    addr2 = {32'h20, 32'h40};
    wdata2 = {32'h0, 32'h1234_5678};
    @(negedge clk);
    req2 = 2'b11;
    #1;
    total++; if (gnt_a !== 2'b10 || mrd_a !== 1'b1 || mwr_a !== 1'b0 || maddr_a !== 32'h20) $display("FAIL blk_issue: got gnt=%b rd=%b wr=%b addr=%h want 10/1/0/20", gnt_a, mrd_a, mwr_a, maddr_a); else pass++;
    @(negedge clk);
    req2 = 2'b01;
    #1;
    total++; if (gnt_a !== 2'b00 || mwr_a !== 1'b0 || mrd_a !== 1'b0) $display("FAIL blk_stall: got gnt=%b wr=%b rd=%b want 00/0/0", gnt_a, mwr_a, mrd_a); else pass++;
    total++; if (busy_a !== 1'b1) $display("FAIL blk_busy: got %b want 1", busy_a); else pass++;
    @(negedge clk);
    #1;
    total++; if (rvalid_a !== 2'b10 || rdata_a !== 32'hDEADBEDF) $display("FAIL blk_rvalid: got %b/%h want 10/deadbedf", rvalid_a, rdata_a); else pass++;
    total++; if (gnt_a !== 2'b01 || mwr_a !== 1'b1 || maddr_a !== 32'h40 || mwd_a !== 32'h1234_5678) $display("FAIL blk_resume: got gnt=%b wr=%b addr=%h data=%h want 01/1/40/12345678", gnt_a, mwr_a, maddr_a, mwd_a); else pass++;
  endtask
  task automatic test_misaligned();
    do_reset();
    req2 = 2'b10; we2 = 2'b11;
    addr2 = {32'h13, 32'h8};
    #1;
    total++; if (gnt_a !== 2'b10 || err_a !== 2'b10) $display("FAIL mis_err: got gnt=%b err=%b want 10/10", gnt_a, err_a); else pass++;
    total++; if (mwr_a !== 1'b0 || mrd_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL mis_nostrobe: got wr=%b rd=%b busy=%b want 0/0/0", mwr_a, mrd_a, busy_a); else pass++;
    @(negedge clk);
    req2 = 2'b01;
    #1;
    total++; if (gnt_a !== 2'b01 || err_a !== 2'b00 || mwr_a !== 1'b1 || maddr_a !== 32'h8) $display("FAIL mis_next: got gnt=%b err=%b wr=%b addr=%h want 01/00/1/8", gnt_a, err_a, mwr_a, maddr_a); else pass++;
  endtask
  task automatic test_fairness();
    logic [3:0]  eg, ev;
    logic [31:0] ed;
    do_reset();
    for (int p = 0; p < 4; p++) addr4[p*32 +: 32] = 32'h1000 + 32'(p) * 32'h40;
    req4 = 4'b1111; we4 = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      ev = (k > 0) ? 4'b0001 << ((k - 1) % 4) : 4'b0000;
      ed = (32'h1000 + 32'((k + 3) % 4) * 32'h40) ^ 32'hDEADBEFF;
      if (k > 0) @(negedge clk);
      #1;
      total++; if (gnt_c !== eg || mrd_c !== 1'b1) $display("FAIL fair_gnt%0d: got gnt=%b rd=%b want %b/1", k, gnt_c, mrd_c, eg); else pass++;
      total++; if (rvalid_c !== ev) $display("FAIL fair_rvalid%0d: got %b want %b", k, rvalid_c, ev); else pass++;
      if (k > 0) begin
        total++; if (rdata_c !== ed) $display("FAIL fair_rdata%0d: got %h want %h", k, rdata_c, ed); else pass++;
      end
      @(negedge clk);
      #1;
      total++; if (gnt_c !== 4'b0000 || busy_c !== 1'b1) $display("FAIL fair_wait%0d: got gnt=%b busy=%b want 0000/1", k, gnt_c, busy_c); else pass++;
    end
    req4 = '0;
  endtask
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_read_blocks();
    test_misaligned();
    test_fairness();
    do_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
